// File: rtl/fp_mul_result_buffer.sv
// Result FIFO for the FP multiplier: first-word fall-through, sticky flag accumulation.
// Define FP_MUL_FLAG_DROP_EN to discard exception products and count them in drop_cnt.
module fp_mul_result_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_result,
    input  logic [2:0]  in_flags,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags,
    input  logic        out_ready,
    input  logic        flag_clear,
    output logic [2:0]  sticky_flags,
    output logic [3:0]  level,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  LvlFull  = 4'(DEPTH);
    localparam logic [AW-1:0] PtrLast = AW'(DEPTH - 1);

    logic [31:0]   mem_data  [DEPTH];
    logic [2:0]    mem_flags [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    level_q, level_d;
    logic [2:0]    sticky_q, sticky_d;

    logic          push;
    logic          pop;
    logic          drop;
    logic          write;

    // Ready depends only on registered occupancy so no comb path from out_ready.
    assign in_ready     = (level_q != LvlFull);
    assign out_valid    = (level_q != 4'd0);
    assign out_data     = mem_data[rd_ptr_q];
    assign out_flags    = mem_flags[rd_ptr_q];
    assign sticky_flags = sticky_q;
    assign level        = level_q;

    always_comb begin
        push = in_valid && in_ready;
        pop  = out_valid && out_ready;
`ifdef FP_MUL_FLAG_DROP_EN
        drop = push && in_flags[2];
`else
        drop = 1'b0;
`endif
        write = push && !drop;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (write) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
        level_d = level_q + {3'b000, write} - {3'b000, pop};
    end

    // Flags of the coinciding push survive a clear; dropped pushes still contribute.
    always_comb begin
        sticky_d = flag_clear ? 3'b000 : sticky_q;
        if (push) begin
            sticky_d = sticky_d | in_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 4'd0;
            sticky_q <= 3'b000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sticky_q <= sticky_d;
        end
    end

    // Storage is cleared on reset so the head reads zero rather than X.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i]  <= 32'd0;
                mem_flags[i] <= 3'b000;
            end
        end else if (write) begin
            mem_data[wr_ptr_q]  <= in_result;
            mem_flags[wr_ptr_q] <= in_flags;
        end
    end

`ifdef FP_MUL_FLAG_DROP_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fp_mul_result_buffer.sv
// Directed self-checking bench for fp_mul_result_buffer (DEPTH 4).
module tb_fp_mul_result_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_result;
    logic [2:0]  in_flags;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_flags;
    logic        out_ready;
    logic        flag_clear;
    logic [2:0]  sticky_flags;
    logic [3:0]  level;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    fp_mul_result_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_flags    (out_flags),
        .out_ready    (out_ready),
        .flag_clear   (flag_clear),
        .sticky_flags (sticky_flags),
        .level        (level),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_result  = 32'd0;
        in_flags   = 3'b000;
        out_ready  = 1'b0;
        flag_clear = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] d, input logic [2:0] f);
        in_valid  = 1'b1;
        in_result = d;
        in_flags  = f;
        step();
        in_valid  = 1'b0;
        in_flags  = 3'b000;
    endtask

    logic [31:0] words [12];

    initial begin
        for (int i = 0; i < 12; i++) words[i] = 32'h3F80_0000 + 32'(i) * 32'h0001_0101;

        // Reset state
        do_reset();
        check("rst_level", 32'(level), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_sticky", 32'(sticky_flags), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);

        // Single push appears next cycle
        push_one(32'h40C0_0000, 3'b000);
        check("one_valid", 32'(out_valid), 32'd1);
        check("one_data", out_data, 32'h40C0_0000);
        check("one_level", 32'(level), 32'd1);

        // Fill past capacity, fifth word held off
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check("fill_ready", 32'(in_ready), 32'd1);
            push_one(words[i], 3'(i));
        end
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_level", 32'(level), 32'd4);
        push_one(32'hDEAD_BEEF, 3'b000);
        check("full_hold_level", 32'(level), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_data", out_data, words[i]);
            check("drain_flags", 32'(out_flags), 32'(3'(i)));
            step();
        end
        out_ready = 1'b0;
        check("drain_level", 32'(level), 32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);

        // Pop while full with in_valid high: no same-cycle push
        for (int i = 0; i < 4; i++) push_one(words[i], 3'b000);
        in_valid  = 1'b1;
        in_result = 32'hCAFE_0000;
        out_ready = 1'b1;
        step();
        idle();
        check("full_pop_level", 32'(level), 32'd3);
        check("full_pop_head", out_data, words[1]);

        // Steady state at level 2 with wrapping pointers
        do_reset();
        push_one(words[0], 3'b000);
        push_one(words[1], 3'b000);
        for (int i = 0; i < 10; i++) begin
            check("ss_head", out_data, words[i]);
            in_valid  = 1'b1;
            in_result = words[i + 2];
            out_ready = 1'b1;
            step();
            check("ss_level", 32'(level), 32'd2);
        end
        idle();
        out_ready = 1'b1;
        check("ss_tail0", out_data, words[10]);
        step();
        check("ss_tail1", out_data, words[11]);
        step();
        out_ready = 1'b0;
        check("ss_empty", 32'(out_valid), 32'd0);

        // Sticky flags and clear with coinciding push
        do_reset();
        push_one(32'h7F80_0000, 3'b010);
        check("sticky_set", 32'(sticky_flags), 32'b010);
        check("sticky_head_flags", 32'(out_flags), 32'b010);
        flag_clear = 1'b1;
        push_one(32'h0000_0001, 3'b001);
        check("sticky_clr_push", 32'(sticky_flags), 32'b001);
        step();
        flag_clear = 1'b0;
        check("sticky_clr_only", 32'(sticky_flags), 32'b000);

        // Exception products: dropped or stored depending on build
        do_reset();
        in_valid  = 1'b1;
        in_result = 32'h7FC0_0000;
        in_flags  = 3'b100;
        for (int i = 0; i < 300; i++) step();
        idle();
`ifdef FP_MUL_FLAG_DROP_EN
        check("exc_level", 32'(level), 32'd0);
        check("exc_drop", 32'(drop_cnt), 32'd255);
`else
        check("exc_level", 32'(level), 32'd4);
        check("exc_drop", 32'(drop_cnt), 32'd0);
`endif
        check("exc_sticky2", 32'(sticky_flags[2]), 32'd1);

        // Reset wins over a concurrent push/pop at level 3
        do_reset();
        for (int i = 0; i < 3; i++) push_one(words[i + 5], 3'b011);
        check("pre_rst_level", 32'(level), 32'd3);
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_result  = 32'h1234_5678;
        in_flags   = 3'b011;
        out_ready  = 1'b1;
        flag_clear = 1'b0;
        step();
        rst = 1'b0;
        idle();
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sticky", 32'(sticky_flags), 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_mul_result_buffer.md
FP_MUL_RESULT_BUFFER -- requirements
Module: fp_mul_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning result FIFO entries; legal values 2, 4, 8 only.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, upstream multiplier product present this cycle.
REQ-005 SHALL have port in_result, input, 32, IEEE-754 single product word.
REQ-006 SHALL have port in_flags, input, 3, {exception, overflow, underflow} from the multiplier.
REQ-007 SHALL have port in_ready, output, 1, buffer can accept this cycle.
REQ-008 SHALL have port out_valid, output, 1, head entry valid.
REQ-009 SHALL have port out_data, output, 32, head entry product word.
REQ-010 SHALL have port out_flags, output, 3, head entry flags, same order as in_flags.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the head entry.
REQ-012 SHALL have port flag_clear, input, 1, clear sticky_flags.
REQ-013 SHALL have port sticky_flags, output, 3, OR of flags of all accepted inputs since last clear.
REQ-014 SHALL have port level, output, 4, current occupancy, 0..DEPTH.
REQ-015 SHALL have port drop_cnt, output, 8, count of discarded exception products.

Function
REQ-016 Push SHALL occur when in_valid and in_ready are both 1; pop SHALL occur when out_valid and out_ready are both 1.
REQ-017 in_ready SHALL equal (level != DEPTH), combinational from registered level only; no dependency on out_ready.
REQ-018 out_valid SHALL equal (level != 0); out_data/out_flags SHALL present the head entry (first-word fall-through).
REQ-019 Latency: product pushed in cycle N SHALL appear at out_data in cycle N+1 at the earliest.
REQ-020 Simultaneous push and pop with level between 1 and DEPTH-1 SHALL leave level unchanged and advance both pointers.
REQ-021 Push and pop with level 0 SHALL not be possible (out_valid 0); push SHALL be accepted and level becomes 1.
REQ-022 With level DEPTH, in_valid SHALL be ignored; a pop in that cycle SHALL reduce level to DEPTH-1 without a same-cycle push.
REQ-023 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-024 Data path SHALL not alter in_result or in_flags; words SHALL exit in acceptance order.
REQ-025 sticky_flags SHALL set per bit from in_flags on every accepted push, including dropped ones.
REQ-026 When flag_clear and a flag-setting push coincide, the new push flags SHALL remain set; other bits SHALL clear.
REQ-027 out_* values SHALL be don't-care when out_valid is 0 but SHALL not be X after reset.

Reset
REQ-028 With rst high at a clock edge: level 0, pointers 0, sticky_flags 0, drop_cnt 0, out_valid 0, in_ready 1.
REQ-029 Reset SHALL take priority over push, pop and flag_clear in the same cycle; in-flight entries SHALL be discarded.
REQ-030 Storage array contents SHALL be reset to 0 so out_data and out_flags read 0 after reset.

Configuration
REQ-031 Macro FP_MUL_FLAG_DROP_EN SHALL select exception filtering.
REQ-032 Defined: accepted push with in_flags[2]=1 SHALL not be written, level unchanged; drop_cnt increments by 1 and saturates at 255.
REQ-033 Not defined: every accepted push SHALL be stored; drop_cnt SHALL be tied to 0.

Verification
REQ-034 Reset, then push 0x40C00000 flags 000 with out_ready 0 -> next cycle out_valid 1, out_data 0x40C00000, level 1.
REQ-035 Push 5 words with out_ready 0, DEPTH 4 -> in_ready 0 after fourth; fifth held; level 4; drain yields first four in order.
REQ-036 At level 2, push and pop same cycle for 10 cycles -> level stays 2; pointers wrap; order preserved.
REQ-037 Push 0x7F800000 flags 010, then flag_clear with push flags 001 -> sticky_flags 010, then 001.
REQ-038 FP_MUL_FLAG_DROP_EN defined: push flags 100 x300 -> level 0, drop_cnt 255, sticky_flags[2] 1; undefined -> level reaches 4, drop_cnt 0.
REQ-039 Assert rst at level 3 during a push -> next cycle level 0, out_valid 0, sticky_flags 0, out_data 0.
